// File: rtl/apo_router_param.sv
// apo_router_param: buffered router node for the circulant NoC C(N; S1, S1+1).
// Five input FIFOs (local inject + four ring links) feed four registered ring
// outputs and one registered eject port through a round-robin, one-pop-per-cycle switch.
// Optional build macro: APO_ROUTER_STATS_EN adds stat_deliv / stat_drop counters.
module apo_router_param #(
    parameter int N         = 9,
    parameter int S1        = 2,
    parameter int KW        = $clog2(N) + 1,
    parameter int PAYLOAD_W = 8,
    parameter int DEPTH     = 4,
    parameter int PW        = 2 * KW + PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KW-2:0]        router_name,
    input  logic [4:0]           in_valid,
    input  logic [5*PW-1:0]      in_data,
    output logic [4:0]           in_ready,
    output logic [3:0]           out_valid,
    output logic [4*PW-1:0]      out_data,
    input  logic [3:0]           out_ready,
    output logic                 ej_valid,
    output logic [PAYLOAD_W-1:0] ej_data,
    input  logic                 ej_ready
`ifdef APO_ROUTER_STATS_EN
    ,
    output logic [15:0]          stat_deliv,
    output logic [15:0]          stat_drop
`endif
);

    localparam int NI = 5;
    localparam int NO = 4;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Output selectors; ring indices match the out_valid bit order.
    localparam logic [2:0] T_R1 = 3'd0;
    localparam logic [2:0] T_R2 = 3'd1;
    localparam logic [2:0] T_L1 = 3'd2;
    localparam logic [2:0] T_L2 = 3'd3;
    localparam logic [2:0] T_EJ = 3'd4;

    // Minimal-hop (r1, r2) decomposition of the distance from name to d.
    // r1 counts S1 hops, r2 counts S1+1 hops; negative means the L direction.
    function automatic logic [2*KW-1:0] local_route(input int d, input int name);
        int   k;
        int   alpha;
        int   beta;
        int   r1;
        int   r2;
        logic sgn;
        k   = (d >= name) ? d - name : name - d;
        sgn = (d <= name);
        if (k > N / 2) begin
            k   = N - k;
            sgn = ~sgn;
        end
        beta  = k % S1;
        alpha = k / S1 - beta;
        if (alpha >= beta - S1 && alpha <= S1) begin
            r1 = alpha;
            r2 = beta;
        end else if (alpha < beta - S1) begin
            r1 = alpha + S1 + 1;
            r2 = beta - S1;
        end else begin
            r1 = alpha - S1 - 1;
            r2 = beta + S1;
        end
        if (sgn) begin
            r1 = -r1;
            r2 = -r2;
        end
        return {r1[KW-1:0], r2[KW-1:0]};
    endfunction

    logic [NI-1:0] empty;
    logic [NI-1:0] pop;
    logic [NI-1:0] req;
    logic [NI-1:0] drop;
    logic [PW-1:0] next_pkt [NI];
    logic [2:0]    tgt [NI];
    logic [4:0]    tgt_free;

    logic [2:0]    rr_ptr_reg;
    logic          grant_valid;
    logic [2:0]    grant;
    logic [PW-1:0] win_pkt;
    logic [2:0]    win_tgt;
    logic          win_drop;
    logic          load;

    logic          ej_valid_reg;
    logic [PAYLOAD_W-1:0] ej_data_reg;

    genvar gi;

    // ------------------------------------------------------------------
    // Input FIFOs and per-head route decode
    // ------------------------------------------------------------------
    for (gi = 0; gi < NI; gi++) begin : g_in
        logic [PW-1:0] mem [DEPTH];
        logic [AW-1:0] wr_ptr_reg;
        logic [AW-1:0] rd_ptr_reg;
        logic [CW-1:0] count_reg;
        logic          push;
        logic          full;
        logic [PW-1:0] head;
        logic [KW-1:0] r1;
        logic [KW-1:0] r2;
        logic [KW-1:0] nr1;
        logic [KW-1:0] nr2;
        logic [2:0]    tgt_w;
        logic          drop_w;

        // A full FIFO refuses input even when it is popped the same cycle.
        assign full         = (count_reg == CW'(DEPTH));
        assign empty[gi]    = (count_reg == '0);
        assign in_ready[gi] = ~full;
        assign push         = in_valid[gi] & ~full;
        assign head         = mem[rd_ptr_reg];

        // FIFO storage write
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= in_data[gi*PW +: PW];
            end
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                case ({push, pop[gi]})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end

        // Head decode: route local packets, pick the output port, step the counters
        always_comb begin
            r1     = head[PW-1 -: KW];
            r2     = head[PW-KW-1 -: KW];
            drop_w = 1'b0;
            if (gi == 0) begin
                drop_w   = (int'(head[PW-KW-1 -: KW]) >= N);
                {r1, r2} = local_route(int'(head[PW-KW-1 -: KW]), int'(router_name));
            end
            nr1   = r1;
            nr2   = r2;
            tgt_w = T_EJ;
            if (r1 != '0) begin
                if (r1[KW-1]) begin
                    tgt_w = T_L1;
                    nr1   = r1 + KW'(1);
                end else begin
                    tgt_w = T_R1;
                    nr1   = r1 - KW'(1);
                end
            end else if (r2 != '0) begin
                if (r2[KW-1]) begin
                    tgt_w = T_L2;
                    nr2   = r2 + KW'(1);
                end else begin
                    tgt_w = T_R2;
                    nr2   = r2 - KW'(1);
                end
            end
        end

        assign drop[gi]     = drop_w;
        assign tgt[gi]      = tgt_w;
        assign next_pkt[gi] = {nr1, nr2, head[PAYLOAD_W-1:0]};
        // Dropped heads need no output register, so they never stall.
        assign req[gi]      = ~empty[gi] & (drop_w | tgt_free[tgt_w]);
        assign pop[gi]      = grant_valid & (grant == 3'(gi));
    end

    // An output register can take a packet if it is empty or draining this cycle.
    for (gi = 0; gi < NO; gi++) begin : g_free
        assign tgt_free[gi] = ~out_valid[gi] | out_ready[gi];
    end
    assign tgt_free[4] = ~ej_valid_reg | ej_ready;

    // ------------------------------------------------------------------
    // Round-robin arbitration and winner mux
    // ------------------------------------------------------------------

    // First requesting input at or after the pointer wins the single pop
    always_comb begin : arb
        int idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int off = 0; off < NI; off++) begin
            idx = (int'(rr_ptr_reg) + off) % NI;
            if (!grant_valid && req[3'(idx)]) begin
                grant_valid = 1'b1;
                grant       = 3'(idx);
            end
        end
    end

    // Select the winning input's outgoing packet, target and drop flag
    always_comb begin
        win_pkt  = '0;
        win_tgt  = T_EJ;
        win_drop = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (grant == 3'(i)) begin
                win_pkt  = next_pkt[i];
                win_tgt  = tgt[i];
                win_drop = drop[i];
            end
        end
    end

    assign load = grant_valid & ~win_drop;

    // Pointer moves one past the winner; unchanged when nobody is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (grant_valid) begin
            rr_ptr_reg <= (grant == 3'(NI - 1)) ? 3'd0 : grant + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    for (gi = 0; gi < NO; gi++) begin : g_out
        logic          valid_reg;
        logic [PW-1:0] data_reg;

        // Hold valid/data until the handshake; a same-edge reload wins over the clear
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (load && win_tgt == 3'(gi)) begin
                valid_reg <= 1'b1;
                data_reg  <= win_pkt;
            end else if (out_ready[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign out_valid[gi]           = valid_reg;
        assign out_data[gi*PW +: PW]   = data_reg;
    end

    // Eject register: same hold/reload rule, payload only
    always_ff @(posedge clk) begin
        if (rst) begin
            ej_valid_reg <= 1'b0;
            ej_data_reg  <= '0;
        end else if (load && win_tgt == T_EJ) begin
            ej_valid_reg <= 1'b1;
            ej_data_reg  <= win_pkt[PAYLOAD_W-1:0];
        end else if (ej_ready) begin
            ej_valid_reg <= 1'b0;
        end
    end

    assign ej_valid = ej_valid_reg;
    assign ej_data  = ej_data_reg;

`ifdef APO_ROUTER_STATS_EN
    logic [15:0] stat_deliv_reg;
    logic [15:0] stat_drop_reg;

    // Saturating counters of eject handshakes and out-of-range drops
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_deliv_reg <= '0;
            stat_drop_reg  <= '0;
        end else begin
            if (ej_valid_reg && ej_ready && stat_deliv_reg != 16'hFFFF) begin
                stat_deliv_reg <= stat_deliv_reg + 16'd1;
            end
            if (grant_valid && win_drop && stat_drop_reg != 16'hFFFF) begin
                stat_drop_reg <= stat_drop_reg + 16'd1;
            end
        end
    end

    assign stat_deliv = stat_deliv_reg;
    assign stat_drop  = stat_drop_reg;
`endif

endmodule

// File: tb/tb_apo_router_param.sv
// Bench for apo_router_param (N=9, S1=2, DEPTH=4, PAYLOAD_W=8).
// Single-hop routing vectors come from a table; backpressure, arbitration
// rotation and mid-stream reset are hand-written sequences. A negedge monitor
// pops expected packets from per-port scoreboard queues on every handshake.
module tb_apo_router_param;
    localparam int N         = 9;
    localparam int S1        = 2;
    localparam int KW        = 5;
    localparam int PAYLOAD_W = 8;
    localparam int DEPTH     = 4;
    localparam int PW        = 2 * KW + PAYLOAD_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [KW-2:0]        router_name;
    logic [4:0]           in_valid;
    logic [5*PW-1:0]      in_data;
    logic [4:0]           in_ready;
    logic [3:0]           out_valid;
    logic [4*PW-1:0]      out_data;
    logic [3:0]           out_ready;
    logic                 ej_valid;
    logic [PAYLOAD_W-1:0] ej_data;
    logic                 ej_ready;
`ifdef APO_ROUTER_STATS_EN
    logic [15:0]          stat_deliv;
    logic [15:0]          stat_drop;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [PW-1:0] exp_q [4][$];
    logic [7:0]    ej_q [$];
    logic [7:0]    in_q [5][$];
    bit            rr_mode = 1'b0;
    int            rr_exp  = 0;

    apo_router_param #(
        .N(N), .S1(S1), .KW(KW), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .router_name(router_name),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .ej_valid(ej_valid),
        .ej_data(ej_data),
        .ej_ready(ej_ready)
`ifdef APO_ROUTER_STATS_EN
        ,
        .stat_deliv(stat_deliv),
        .stat_drop(stat_drop)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input int r1, input int r2, input logic [7:0] p);
        return {r1[KW-1:0], r2[KW-1:0], p};
    endfunction

    // Monitor: every handshake is one transaction, checked against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int t = 0; t < 4; t++) begin
                if (out_valid[t] && out_ready[t]) begin
                    $display("ring port %0d sends %h", t, out_data[t*PW +: PW]);
                    n_cmp++;
                    if (exp_q[t].size() == 0) begin
                        n_fail++;
                        $display("FAIL ring_out_unexpected port %0d: got %h required none", t, out_data[t*PW +: PW]);
                    end else begin
                        logic [PW-1:0] e;
                        e = exp_q[t].pop_front();
                        n_cmp--;
                        check($sformatf("ring_out_p%0d", t), 32'(out_data[t*PW +: PW]), 32'(e));
                    end
                end
            end
            if (ej_valid && ej_ready) begin
                $display("eject delivers %h", ej_data);
                if (rr_mode) begin
                    n_cmp++;
                    if (in_q[rr_exp].size() == 0) begin
                        n_fail++;
                        $display("FAIL rr_eject input %0d: got %h required queued packet", rr_exp, ej_data);
                    end else begin
                        logic [7:0] e;
                        e = in_q[rr_exp].pop_front();
                        n_cmp--;
                        check("rr_eject_order", 32'(ej_data), 32'(e));
                    end
                    rr_exp = (rr_exp + 1) % 5;
                end else begin
                    n_cmp++;
                    if (ej_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL eject_unexpected: got %h required none", ej_data);
                    end else begin
                        logic [7:0] e;
                        e = ej_q.pop_front();
                        n_cmp--;
                        check("eject_data", 32'(ej_data), 32'(e));
                    end
                end
            end
        end
    end

    typedef struct {
        int         name;
        int         port;
        int         r1;
        int         r2;      // destination for local inject
        logic [7:0] pay;
        int         ep;      // 0..3 ring output, 4 eject, 5 dropped
        int         er1;
        int         er2;
    } vec_t;

    initial begin
        vec_t       v [20];
        int         sent;
        logic [4:0] acc;
        int         seq [5];

        // From node 0, d=5 folds to 4 backward hops -> (-2,0): leaves on L1 with r1=-1.
        v[0]  = '{0, 0,  3,  4, 8'hA5, 0,  1,  0};
        v[1]  = '{0, 0,  0,  5, 8'h3C, 2, -1,  0};
        v[2]  = '{0, 0,  0,  7, 8'h77, 2,  0,  0};
        v[3]  = '{0, 0,  0,  0, 8'h5A, 4,  0,  0};
        v[4]  = '{0, 0,  0,  1, 8'h11, 2,  0,  1};
        v[5]  = '{0, 0,  0,  3, 8'h33, 1,  0,  0};
        v[6]  = '{0, 0,  0,  8, 8'h88, 0,  0, -1};
        v[7]  = '{0, 0,  0,  6, 8'h66, 3,  0,  0};
        v[8]  = '{0, 0,  0,  2, 8'h22, 0,  0,  0};
        v[9]  = '{0, 0,  0, 12, 8'hC1, 5,  0,  0};
        v[10] = '{0, 0,  0,  9, 8'hC2, 5,  0,  0};
        v[11] = '{2, 1,  0,  1, 8'hA5, 1,  0,  0};
        v[12] = '{5, 2,  0,  0, 8'hA5, 4,  0,  0};
        v[13] = '{0, 3, -2,  1, 8'h99, 2, -1,  1};
        v[14] = '{0, 4,  0, -2, 8'h42, 3,  0, -1};
        v[15] = '{0, 1,  0,  2, 8'h15, 1,  0,  1};
        v[16] = '{4, 0,  0,  0, 8'h16, 2, -1,  0};
        v[17] = '{7, 0,  0,  1, 8'h17, 1,  0,  0};
        v[18] = '{5, 0,  0,  5, 8'h18, 4,  0,  0};
        v[19] = '{0, 1,  1, -1, 8'h19, 0,  0, -1};

        router_name = '0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 4'hF;
        ej_ready    = 1'b1;
        rst         = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_ej_valid", 32'(ej_valid), 32'h0);
        check("rst_out_data_zero", 32'(out_data == '0), 32'h1);
        check("rst_ej_data", 32'(ej_data), 32'h0);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'h1F);

        // Table: single packets through an idle router
        for (int i = 0; i < 20; i++) begin
            router_name = 4'(v[i].name);
            in_data     = '0;
            in_data[v[i].port*PW +: PW] = mk(v[i].r1, v[i].r2, v[i].pay);
            in_valid    = 5'(1) << v[i].port;
            check("in_ready_idle", 32'(in_ready[v[i].port]), 32'h1);
            if (v[i].ep < 4) exp_q[v[i].ep].push_back(mk(v[i].er1, v[i].er2, v[i].pay));
            else if (v[i].ep == 4) ej_q.push_back(v[i].pay);
            tick();
            in_valid = '0;
            if (i == 0) begin
                check("latency_edge_E", 32'(out_valid[0]), 32'h0);
                tick();
                check("latency_edge_E1", 32'(out_valid[0]), 32'h1);
            end
            repeat (4) tick();
        end
`ifdef APO_ROUTER_STATS_EN
        begin
            int nd;
            int nx;
            nd = 0;
            nx = 0;
            for (int i = 0; i < 20; i++) begin
                if (v[i].ep == 4) nd++;
                if (v[i].ep == 5) nx++;
            end
            check("stat_deliv", 32'(stat_deliv), 32'(nd));
            check("stat_drop", 32'(stat_drop), 32'(nx));
        end
`endif

        // Backpressure: R1 blocked, only FIFO depth + output register accepted
        rst = 1'b1;
        tick();
        rst = 1'b0;
        router_name = '0;
        out_ready   = 4'b1110;
        sent        = 0;
        for (int c = 0; c < 10; c++) begin
            in_data[0 +: PW] = mk(0, 4, 8'hB0 + 8'(sent));
            in_valid = 5'b00001;
            acc      = in_valid & in_ready;
            tick();
            if (acc[0]) begin
                exp_q[0].push_back(mk(1, 0, 8'hB0 + 8'(sent)));
                sent++;
            end
        end
        check("bp_accepted", 32'(sent), 32'd5);
        check("bp_in_ready_low", 32'(in_ready[0]), 32'h0);
        in_valid  = '0;
        out_ready = 4'hF;
        repeat (10) tick();
        check("bp_in_ready_back", 32'(in_ready[0]), 32'h1);

        // Arbitration: every input streams eject-bound packets, grants must rotate
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rr_mode = 1'b1;
        rr_exp  = 0;
        for (int i = 0; i < 5; i++) seq[i] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 5; i++) begin
                in_data[i*PW +: PW] = mk(0, 0, {seq[i][4:0], 3'(i)});
            end
            in_valid = 5'h1F;
            acc      = in_valid & in_ready;
            tick();
            for (int i = 0; i < 5; i++) begin
                if (acc[i]) begin
                    in_q[i].push_back({seq[i][4:0], 3'(i)});
                    seq[i]++;
                end
            end
        end
        // Reset mid-stream: everything in flight is discarded
        rst = 1'b1;
        tick();
        check("rst_mid_out_valid", 32'(out_valid), 32'h0);
        check("rst_mid_ej_valid", 32'(ej_valid), 32'h0);
        check("rst_mid_in_ready", 32'(in_ready), 32'h1F);
        in_valid = '0;
        rst      = 1'b0;
        rr_mode  = 1'b0;
        for (int i = 0; i < 5; i++) in_q[i].delete();
        repeat (5) tick();
        check("post_rst_ej_idle", 32'(ej_valid), 32'h0);

        // Everything expected must have been seen
        for (int t = 0; t < 4; t++) check($sformatf("left_in_q%0d", t), 32'(exp_q[t].size()), 32'd0);
        check("left_in_ej_q", 32'(ej_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
